// File: rtl/memory_arbiter.sv
// memory_arbiter: CPU / loader access arbiter in front of a single-port memory.
// Define ARBITER_ROUND_ROBIN_EN for round-robin ties; default is fixed port-0 priority.
module memory_arbiter #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     p0_req,
  input  logic [ADDRESS_WIDTH-1:0] p0_address,
  input  logic [DATA_WIDTH-1:0]    p0_data_in,
  input  logic [DATA_WIDTH/8-1:0]  p0_write_mask,
  input  logic                     p0_write_enable,
  output logic                     p0_ack,
  output logic [DATA_WIDTH-1:0]    p0_data_out,

  input  logic                     p1_req,
  input  logic [ADDRESS_WIDTH-1:0] p1_address,
  input  logic [DATA_WIDTH-1:0]    p1_data_in,
  input  logic [DATA_WIDTH/8-1:0]  p1_write_mask,
  input  logic                     p1_write_enable,
  output logic                     p1_ack,
  output logic [DATA_WIDTH-1:0]    p1_data_out,

  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_data_in,
  output logic [DATA_WIDTH/8-1:0]  mem_write_mask,
  output logic                     mem_write_enable,
  input  logic [DATA_WIDTH-1:0]    mem_data_out
);

  localparam int MW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]    data;
    logic [MW-1:0]            mask;
    logic                     write;
  } cmd_t;

  state_t     state;
  logic       grant;
  logic [1:0] ack_q;
  logic       pick1;
  cmd_t       p0_cmd;
  cmd_t       p1_cmd;
  cmd_t       sel_cmd;

  assign p0_cmd = '{p0_address, p0_data_in, p0_write_mask, p0_write_enable};
  assign p1_cmd = '{p1_address, p1_data_in, p1_write_mask, p1_write_enable};

  // grant holds the last winner; on a tie round-robin favours the other port
  always_comb begin
    pick1 = 1'b0;
`ifdef ARBITER_ROUND_ROBIN_EN
    unique case (1'b1)
      (p0_req && p1_req):  pick1 = ~grant;
      (p1_req && !p0_req): pick1 = 1'b1;
      default:             pick1 = 1'b0;
    endcase
`else
    pick1 = p1_req && !p0_req;
`endif
  end

  assign sel_cmd = pick1 ? p1_cmd : p0_cmd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      grant            <= 1'b1;
      ack_q            <= 2'b00;
      mem_address      <= '0;
      mem_data_in      <= '0;
      mem_write_mask   <= '1;
      mem_write_enable <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (p0_req || p1_req) begin
            grant            <= pick1;
            mem_address      <= sel_cmd.address;
            mem_data_in      <= sel_cmd.data;
            mem_write_mask   <= sel_cmd.mask;
            mem_write_enable <= sel_cmd.write;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          mem_write_enable <= 1'b0;
          ack_q            <= grant ? 2'b10 : 2'b01;
          state            <= DONE;
        end
        DONE: begin
          ack_q <= 2'b00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign p0_ack = ack_q[0];
  assign p1_ack = ack_q[1];

  // registered memory read data lands in DONE, the only cycle an ack is high
  assign p0_data_out = ack_q[0] ? mem_data_out : '0;
  assign p1_data_out = ack_q[1] ? mem_data_out : '0;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed and randomized checks of memory_arbiter
// against a behavioural memory/arbitration model.
module tb_memory_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk;
  logic          reset;
  logic          p0_req, p1_req;
  logic [AW-1:0] p0_address, p1_address;
  logic [DW-1:0] p0_data_in, p1_data_in;
  logic [1:0]    p0_write_mask, p1_write_mask;
  logic          p0_write_enable, p1_write_enable;
  logic          p0_ack, p1_ack;
  logic [DW-1:0] p0_data_out, p1_data_out;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic [1:0]    mem_write_mask;
  logic          mem_write_enable;
  logic [DW-1:0] mem_data_out;

  int n_checks = 0;
  int n_pass   = 0;
  int we_cnt   = 0;

  logic [DW-1:0] mem     [0:2047];
  logic [DW-1:0] ref_mem [0:2047];
  logic [DW-1:0] rd_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  memory_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_address(p0_address), .p0_data_in(p0_data_in),
    .p0_write_mask(p0_write_mask), .p0_write_enable(p0_write_enable),
    .p0_ack(p0_ack), .p0_data_out(p0_data_out),
    .p1_req(p1_req), .p1_address(p1_address), .p1_data_in(p1_data_in),
    .p1_write_mask(p1_write_mask), .p1_write_enable(p1_write_enable),
    .p1_ack(p1_ack), .p1_data_out(p1_data_out),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write_mask(mem_write_mask), .mem_write_enable(mem_write_enable),
    .mem_data_out(mem_data_out)
  );

  // single-port memory with registered read (read-before-write)
  always @(posedge clk) begin
    rd_q <= mem[mem_address[AW-1:1]];
    if (mem_write_enable) begin
      if (!mem_write_mask[0]) mem[mem_address[AW-1:1]][7:0]  <= mem_data_in[7:0];
      if (!mem_write_mask[1]) mem[mem_address[AW-1:1]][15:8] <= mem_data_in[15:8];
    end
  end
  assign mem_data_out = rd_q;

  always @(negedge clk)
    if (mem_write_enable === 1'b1) we_cnt <= we_cnt + 1;

  function automatic logic [DW-1:0] merged(input logic [DW-1:0] old,
                                           input logic [DW-1:0] nw,
                                           input logic [1:0] m);
    merged = old;
    if (!m[0]) merged[7:0]  = nw[7:0];
    if (!m[1]) merged[15:8] = nw[15:8];
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int port, input logic r, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [1:0] m, input logic w);
    if (port == 0) begin
      p0_req = r; p0_address = a; p0_data_in = d;
      p0_write_mask = m; p0_write_enable = w;
    end else begin
      p1_req = r; p1_address = a; p1_data_in = d;
      p1_write_mask = m; p1_write_enable = w;
    end
  endtask

  // called just after a rising edge; returns just after the edge following ack
  task automatic do_access(input int port, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [1:0] m,
                           input logic w, output logic [DW-1:0] rd, output int lat);
    logic got;
    got = 1'b0;
    lat = -1;
    rd  = '0;
    drive(port, 1'b1, a, d, m, w);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((port == 0 ? p0_ack : p1_ack) === 1'b1) begin
        got = 1'b1;
        lat = i;
        rd  = (port == 0) ? p0_data_out : p1_data_out;
      end
    end
    n_checks++;
    if (!got) $display("FAIL ack_timeout port%0d: got no ack, required ack within 40 cycles", port);
    else n_pass++;
    sync();
    drive(port, 1'b0, a, d, m, w);
  endtask

  task automatic apply_reset();
    sync();
    reset = 1'b1;
    drive(0, 1'b0, '0, '0, 2'b11, 1'b0);
    drive(1, 1'b0, '0, '0, 2'b11, 1'b0);
    repeat (2) sync();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW+DW+AW+DW+2+3-1:0] got, exp;
    sync();
    reset = 1'b1;
    repeat (2) sync();
    @(negedge clk);
    got = {p0_ack, p1_ack, mem_write_enable, mem_address, mem_data_in,
           mem_write_mask, p0_data_out, p1_data_out};
    exp = {1'b0, 1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}, 2'b11, {DW{1'b0}}, {DW{1'b0}}};
    n_checks++;
    if (got !== exp) $display("FAIL reset_values: got %h, required %h", got, exp);
    else n_pass++;
    sync();
    reset = 1'b0;
  endtask

  task automatic test_idle();
    logic [DW-1:0] rd;
    int lat;
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks++;
      if ({p0_ack, p1_ack, mem_write_enable} !== 3'b000)
        $display("FAIL idle_quiet c=%0d: got %b, required 000", c,
                 {p0_ack, p1_ack, mem_write_enable});
      else n_pass++;
    end
    sync();
    do_access(0, 12'h000, 16'h0, 2'b11, 1'b0, rd, lat);
    n_checks++;
    if (lat !== 2) $display("FAIL idle_then_latency: got %0d, required 2", lat);
    else n_pass++;
  endtask

  task automatic test_single_read();
    logic [DW-1:0] rd;
    int lat, w0;
    apply_reset();
    w0 = we_cnt;
    do_access(1, 12'h020, 16'h1234, 2'b00, 1'b1, rd, lat);
    ref_mem[11'h010] = merged(ref_mem[11'h010], 16'h1234, 2'b00);
    n_checks++;
    if (we_cnt - w0 !== 1) $display("FAIL preload_we_pulses: got %0d, required 1", we_cnt - w0);
    else n_pass++;
    w0 = we_cnt;
    do_access(0, 12'h020, 16'hFFFF, 2'b00, 1'b0, rd, lat);
    n_checks++;
    if (lat !== 2) $display("FAIL read_latency: got %0d, required 2", lat);
    else n_pass++;
    n_checks++;
    if (rd !== ref_mem[11'h010]) $display("FAIL read_data: got %h, required %h", rd, ref_mem[11'h010]);
    else n_pass++;
    n_checks++;
    if (we_cnt - w0 !== 0) $display("FAIL read_we_low: got %0d pulses, required 0", we_cnt - w0);
    else n_pass++;
  endtask

  task automatic test_byte_write();
    logic [DW-1:0] rd;
    int lat, w0;
    w0 = we_cnt;
    do_access(1, 12'h020, 16'hABCD, 2'b10, 1'b1, rd, lat);
    ref_mem[11'h010] = merged(ref_mem[11'h010], 16'hABCD, 2'b10);
    n_checks++;
    if (we_cnt - w0 !== 1) $display("FAIL byte_write_we_pulses: got %0d, required 1", we_cnt - w0);
    else n_pass++;
    do_access(1, 12'h020, 16'h0, 2'b00, 1'b0, rd, lat);
    n_checks++;
    if (rd !== ref_mem[11'h010]) $display("FAIL low_byte_readback: got %h, required %h", rd, ref_mem[11'h010]);
    else n_pass++;
    do_access(0, 12'h021, 16'h7700, 2'b01, 1'b1, rd, lat);
    ref_mem[11'h010] = merged(ref_mem[11'h010], 16'h7700, 2'b01);
    do_access(0, 12'h020, 16'h0, 2'b00, 1'b0, rd, lat);
    n_checks++;
    if (rd !== ref_mem[11'h010]) $display("FAIL high_byte_readback: got %h, required %h", rd, ref_mem[11'h010]);
    else n_pass++;
  endtask

  task automatic test_tie();
    int last_c;
    logic e0, e1;
    apply_reset();
    drive(0, 1'b1, 12'h020, 16'h0, 2'b11, 1'b0);
    drive(1, 1'b1, 12'h022, 16'h0, 2'b11, 1'b0);
`ifdef ARBITER_ROUND_ROBIN_EN
    last_c = 11;
`else
    last_c = 14;
`endif
    for (int c = 0; c <= last_c; c++) begin
      @(negedge clk);
      e0 = 1'b0;
      e1 = 1'b0;
`ifdef ARBITER_ROUND_ROBIN_EN
      if (c >= 2 && (c - 2) % 3 == 0) begin
        e0 = (((c - 2) / 3) % 2) == 0;
        e1 = !e0;
      end
`else
      e0 = (c >= 2 && c <= 11 && (c - 2) % 3 == 0);
      e1 = (c == 14);
`endif
      n_checks++;
      if ({p0_ack, p1_ack} !== {e0, e1})
        $display("FAIL tie_acks c=%0d: got %b, required %b", c, {p0_ack, p1_ack}, {e0, e1});
      else n_pass++;
      sync();
      if (c == 11) p0_req = 1'b0;
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (3) sync();
  endtask

  task automatic test_reset_in_issue();
    logic [DW-1:0] rd;
    int lat;
    apply_reset();
    drive(0, 1'b1, 12'h040, 16'h5555, 2'b00, 1'b1);
    @(negedge clk);
    sync();
    reset = 1'b1;
    drive(0, 1'b0, 12'h040, 16'h5555, 2'b00, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({mem_write_enable, mem_address} !== {1'b1, 12'h040})
      $display("FAIL issue_outputs: got %b/%h, required 1/040", mem_write_enable, mem_address);
    else n_pass++;
    sync();
    @(negedge clk);
    n_checks++;
    if ({p0_ack, p1_ack, mem_write_enable, mem_address, mem_data_in, mem_write_mask}
        !== {3'b000, 12'h000, 16'h0000, 2'b11})
      $display("FAIL reset_in_issue_outputs: got ack=%b%b we=%b a=%h d=%h m=%b, required 0 0 0 000 0000 11",
               p0_ack, p1_ack, mem_write_enable, mem_address, mem_data_in, mem_write_mask);
    else n_pass++;
    ref_mem[11'h020] = merged(ref_mem[11'h020], 16'h5555, 2'b00);
    sync();
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (p0_ack !== 1'b0) $display("FAIL reset_in_issue_no_ack: got %b, required 0", p0_ack);
    else n_pass++;
    sync();
    do_access(0, 12'h040, 16'h0, 2'b11, 1'b0, rd, lat);
    n_checks++;
    if (rd !== ref_mem[11'h020]) $display("FAIL reset_in_issue_readback: got %h, required %h", rd, ref_mem[11'h020]);
    else n_pass++;
  endtask

  task automatic test_random(input int n_per_port);
    logic [DW-1:0] rd, d;
    int lat;
    bit done0, done1;
    done0 = 1'b0;
    done1 = 1'b0;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      d = DW'($urandom);
      do_access(0, AW'(12'h200 + 2 * i), d, 2'b00, 1'b1, rd, lat);
      ref_mem[11'h100 + 11'(i)] = d;
    end
    fork
      begin
        logic [DW-1:0] rd0;
        int lat0;
        for (int n = 0; n < n_per_port; n++) begin
          repeat ($urandom_range(0, 2)) sync();
          do_access(0, AW'(12'h200 + $urandom_range(0, 15)), DW'($urandom),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rd0, lat0);
        end
        done0 = 1'b1;
      end
      begin
        logic [DW-1:0] rd1;
        int lat1;
        for (int n = 0; n < n_per_port; n++) begin
          repeat ($urandom_range(0, 2)) sync();
          do_access(1, AW'(12'h200 + $urandom_range(0, 15)), DW'($urandom),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rd1, lat1);
        end
        done1 = 1'b1;
      end
      begin
        bit h0 [0:4095];
        bit h1 [0:4095];
        int last_port, last_c, exp_port, k, c;
        logic [AW-1:0] a;
        logic [DW-1:0] dout, other, wd;
        logic [1:0] wm;
        logic w;
        last_port = 0;
        last_c = -100;
        c = 0;
        while (!(done0 && done1) && c < 4000) begin
          @(negedge clk);
          h0[c] = p0_req;
          h1[c] = p1_req;
          if (p0_ack === 1'b1 || p1_ack === 1'b1) begin
            k = (p1_ack === 1'b1) ? 1 : 0;
            if (c >= 2) begin
              exp_port = -1;
              if (h0[c-2] && h1[c-2]) begin
`ifdef ARBITER_ROUND_ROBIN_EN
                exp_port = 1 - last_port;
`else
                exp_port = 0;
`endif
              end else if (h1[c-2]) exp_port = 1;
              else if (h0[c-2]) exp_port = 0;
              n_checks++;
              if ({p0_ack, p1_ack} !== {exp_port == 0, exp_port == 1})
                $display("FAIL rand_winner c=%0d: got acks %b, required port %0d",
                         c, {p0_ack, p1_ack}, exp_port);
              else n_pass++;
            end
            if (last_c >= 0) begin
              n_checks++;
              if (c - last_c < 3) $display("FAIL rand_spacing c=%0d: got %0d, required >=3", c, c - last_c);
              else n_pass++;
            end
            a     = k ? p1_address : p0_address;
            wd    = k ? p1_data_in : p0_data_in;
            wm    = k ? p1_write_mask : p0_write_mask;
            w     = k ? p1_write_enable : p0_write_enable;
            dout  = k ? p1_data_out : p0_data_out;
            other = k ? p0_data_out : p1_data_out;
            n_checks++;
            if (other !== '0) $display("FAIL rand_other_dout c=%0d: got %h, required 0000", c, other);
            else n_pass++;
            if (!w) begin
              n_checks++;
              if (dout !== ref_mem[a[AW-1:1]])
                $display("FAIL rand_read c=%0d port%0d a=%h: got %h, required %h",
                         c, k, a, dout, ref_mem[a[AW-1:1]]);
              else n_pass++;
            end else begin
              ref_mem[a[AW-1:1]] = merged(ref_mem[a[AW-1:1]], wd, wm);
            end
            last_port = k;
            last_c = c;
          end
          c++;
        end
        if (c >= 4000) begin
          n_checks++;
          $display("FAIL rand_timeout: got %0d cycles, required completion", c);
        end
      end
    join
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, '0, '0, 2'b11, 1'b0);
    drive(1, 1'b0, '0, '0, 2'b11, 1'b0);
    test_reset();
    test_idle();
    test_single_read();
    test_byte_write();
    test_tie();
    test_reset_in_issue();
    test_random(60);
    repeat (3) sync();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
